// File: rtl/dmem_port_arbiter.sv
// Shares data_mem between the CPU load/store path and a host port; host granted >=1 cycle after host_req, CPU stalled
// while the host owns the port, CPU forcibly stalled after MAX_WAIT blocked cycles. Optional host bursts: DMEM_HOST_BURST_EN.
module dmem_port_arbiter #(
  parameter int MAX_WAIT  = 8,
  parameter int BURST_LEN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_active,
  input  logic        cpu_we,
  input  logic [31:0] cpu_adr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_funct3,
  output logic        cpu_stall,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [31:0] host_adr,
  input  logic [31:0] host_wdata,
  output logic        host_gnt,
  output logic        host_rvalid,
  output logic [31:0] host_rdata,
  output logic        mem_we,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_rdata
);

  localparam int WaitW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT - 1);
  localparam logic [2:0] WordFunct3 = 3'b010;

  if (MAX_WAIT < 1 || BURST_LEN < 1) begin : gBadParams
    $error("dmem_port_arbiter: MAX_WAIT and BURST_LEN must both be >= 1");
  end

  typedef enum logic {CPU_OWN = 1'b0, HOST_OWN = 1'b1} arbState_t;

  arbState_t        state;
  arbState_t        stateNxt;
  logic [WaitW-1:0] waitCnt;
  logic             hostAcc;
  logic             hostLast;

  // An access is accepted in any HOST_OWN cycle where the host still requests.
  assign hostAcc = (state == HOST_OWN) && host_req;

`ifdef DMEM_HOST_BURST_EN
  localparam int BurstW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  logic [BurstW-1:0] burstCnt;

  assign hostLast = (burstCnt == BurstW'(BURST_LEN - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      burstCnt <= '0;
    end else if (stateNxt != HOST_OWN) begin
      burstCnt <= '0;
    end else if (hostAcc) begin
      burstCnt <= burstCnt + 1'b1;
    end
  end
`else
  assign hostLast = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= CPU_OWN;
    end else begin
      state <= stateNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    case (state)
      CPU_OWN:  if (host_req && (!cpu_active || waitCnt == WaitMax)) stateNxt = HOST_OWN;
      HOST_OWN: if (!host_req || hostLast) stateNxt = CPU_OWN;
      default:  stateNxt = CPU_OWN;
    endcase
  end

  always_comb begin
    cpu_stall  = 1'b0;
    mem_we     = cpu_we & cpu_active;
    mem_adr    = cpu_adr;
    mem_wdata  = cpu_wdata;
    mem_funct3 = cpu_funct3;
    if (state == HOST_OWN) begin
      cpu_stall  = cpu_active;
      mem_we     = host_req & host_we;
      mem_adr    = host_adr;
      mem_wdata  = host_wdata;
      mem_funct3 = WordFunct3;
    end
  end

  // State is a single flop, so the grant is glitch-free straight off it.
  assign host_gnt = (state == HOST_OWN);

  // Counts cycles a pending host request loses to the CPU; saturates at the forcing point.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      waitCnt <= '0;
    end else if (state != CPU_OWN || !host_req || stateNxt == HOST_OWN) begin
      waitCnt <= '0;
    end else if (cpu_active && waitCnt != WaitMax) begin
      waitCnt <= waitCnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      host_rvalid <= hostAcc & ~host_we;
      if (hostAcc && !host_we) host_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural data_mem and a stalling CPU store stream.
`timescale 1ns/1ps
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpuActive, cpuWe, cpuStall;
  logic [31:0] cpuAdr, cpuWdata;
  logic [2:0]  cpuFunct3;
  logic        hostReq, hostWe, hostGnt, hostRvalid;
  logic [31:0] hostAdr, hostWdata, hostRdata;
  logic        memWe;
  logic [31:0] memAdr, memWdata, memRdata;
  logic [2:0]  memFunct3;

  logic [31:0] mem [0:255];
  int hostWrCnt = 0;
  int cpuWrCnt  = 0;
  int checks    = 0;
  int errors    = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.MAX_WAIT(8), .BURST_LEN(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_active(cpuActive), .cpu_we(cpuWe), .cpu_adr(cpuAdr), .cpu_wdata(cpuWdata),
    .cpu_funct3(cpuFunct3), .cpu_stall(cpuStall),
    .host_req(hostReq), .host_we(hostWe), .host_adr(hostAdr), .host_wdata(hostWdata),
    .host_gnt(hostGnt), .host_rvalid(hostRvalid), .host_rdata(hostRdata),
    .mem_we(memWe), .mem_adr(memAdr), .mem_wdata(memWdata), .mem_funct3(memFunct3),
    .mem_rdata(memRdata)
  );

  assign memRdata = mem[memAdr[9:2]];

  always @(posedge clk) begin
    if (memWe) begin
      mem[memAdr[9:2]] <= memWdata;
      if (hostGnt) hostWrCnt <= hostWrCnt + 1;
      else         cpuWrCnt  <= cpuWrCnt + 1;
    end
  end

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    int h0, c0, idx, gntCycle, stallCnt, good, n;
    logic hostDone, gntSeen;
    logic [15:0] gntHist;
    logic [15:0] expHist;

    // Reset with random inputs
    reset = 1'b1;
    cpuActive = 1'b1; cpuWe = 1'b1; cpuAdr = $urandom; cpuWdata = $urandom; cpuFunct3 = 3'b001;
    hostReq = 1'b1; hostWe = 1'($urandom); hostAdr = $urandom; hostWdata = $urandom;
    #1 reset = 1'b0;
    #2;
    checkEq("rst_gnt", 32'(hostGnt), 0);
    checkEq("rst_stall", 32'(cpuStall), 0);
    checkEq("rst_rvalid", 32'(hostRvalid), 0);
    checkEq("rst_rdata", hostRdata, 0);
    checkEq("rst_mux_adr", memAdr, cpuAdr);
    checkEq("rst_mux_wdata", memWdata, cpuWdata);
    checkEq("rst_mux_f3", 32'(memFunct3), 32'd1);
    checkEq("rst_mux_we", 32'(memWe), 1);
    smp(); smp();
    checkEq("rst_hold_gnt", 32'(hostGnt), 0);
    cyc();
    reset = 1'b1; cpuActive = 1'b0; cpuWe = 1'b0; hostReq = 1'b0;

    // Idle CPU: host write then read back
    h0 = hostWrCnt;
    cyc(); hostReq = 1'b1; hostWe = 1'b1; hostAdr = 32'h40; hostWdata = 32'hDEADBEEF;
    smp(); checkEq("wr_gnt_latency", 32'(hostGnt), 0);
    cyc(); smp();
    checkEq("wr_gnt", 32'(hostGnt), 1);
    checkEq("wr_mem_we", 32'(memWe), 1);
    checkEq("wr_mem_adr", memAdr, 32'h40);
    checkEq("wr_mem_f3", 32'(memFunct3), 32'd2);
    cyc(); hostReq = 1'b0;
    smp();
    checkEq("wr_gnt_drop", 32'(hostGnt), 0);
    checkEq("wr_mem_data", mem[16], 32'hDEADBEEF);
    checkEq("wr_pulses", 32'(hostWrCnt - h0), 1);

    cyc(); hostReq = 1'b1; hostWe = 1'b0; hostAdr = 32'h40;
    smp(); checkEq("rd_gnt_latency", 32'(hostGnt), 0);
    cyc(); smp();
    checkEq("rd_gnt", 32'(hostGnt), 1);
    checkEq("rd_rvalid_early", 32'(hostRvalid), 0);
    cyc(); hostReq = 1'b0;
    smp();
    checkEq("rd_rvalid", 32'(hostRvalid), 1);
    checkEq("rd_rdata", hostRdata, 32'hDEADBEEF);
    cyc(); smp();
    checkEq("rd_rvalid_pulse", 32'(hostRvalid), 0);
    checkEq("rd_rdata_hold", hostRdata, 32'hDEADBEEF);

    // Starvation guard: continuous CPU stores, host request rises with them
    c0 = cpuWrCnt; h0 = hostWrCnt;
    idx = 0; gntCycle = -1; stallCnt = 0; hostDone = 1'b0;
    hostWe = 1'b1; hostAdr = 32'h200; hostWdata = 32'hCAFE0001;
    for (int k = 0; k < 40 && idx < 12; k++) begin
      cyc();
      cpuActive = 1'b1; cpuWe = 1'b1; cpuFunct3 = 3'b010;
      cpuAdr = 32'h80 + 32'(idx * 4); cpuWdata = 32'h1000 + 32'(idx);
      hostReq = !hostDone;
      smp();
      if (hostGnt && gntCycle < 0) gntCycle = k;
      if (cpuStall) stallCnt++;
      if (hostGnt && hostReq) hostDone = 1'b1;
      if (!cpuStall) idx++;
    end
    cyc(); cpuActive = 1'b0; cpuWe = 1'b0; hostReq = 1'b0;
    good = 0;
    for (int i = 0; i < 12; i++) if (mem[32 + i] == 32'h1000 + 32'(i)) good++;
    checkEq("starve_gnt_cycle", 32'(gntCycle), 32'd8);
    checkEq("starve_stall_cycles", 32'(stallCnt), 1);
    checkEq("starve_stores_done", 32'(idx), 32'd12);
    checkEq("starve_stores_ok", 32'(good), 32'd12);
    checkEq("starve_cpu_writes", 32'(cpuWrCnt - c0), 32'd12);
    checkEq("starve_host_write", mem[128], 32'hCAFE0001);
    checkEq("starve_host_count", 32'(hostWrCnt - h0), 1);

    // Abort during CPU traffic, then a fresh request must wait the full MAX_WAIT again
    h0 = hostWrCnt;
    cyc(); cpuActive = 1'b1; cpuWe = 1'b0; cpuAdr = 32'h84;
    hostReq = 1'b1; hostWe = 1'b1; hostAdr = 32'h204; hostWdata = 32'h5555AAAA;
    smp(); gntSeen = hostGnt;
    for (int k = 0; k < 3; k++) begin
      cyc(); hostReq = 1'b0;
      smp(); gntSeen = gntSeen | hostGnt;
    end
    checkEq("abort_no_gnt", 32'(gntSeen), 0);
    checkEq("abort_no_write", 32'(hostWrCnt - h0), 0);
    gntCycle = -1;
    for (int k = 0; k < 20 && gntCycle < 0; k++) begin
      cyc(); hostReq = 1'b1;
      smp(); if (hostGnt) gntCycle = k;
    end
    cyc(); hostReq = 1'b0; cpuActive = 1'b0;
    checkEq("abort_regnt_cycle", 32'(gntCycle), 32'd8);
    checkEq("abort_regnt_write", mem[129], 32'h5555AAAA);

    // Request withdrawn while granted: no access, ownership returns
    h0 = hostWrCnt;
    cyc(); hostReq = 1'b1; hostWe = 1'b1; hostAdr = 32'h208; hostWdata = 32'h00001234;
    smp();
    cyc(); hostReq = 1'b0;
    smp();
    checkEq("habort_gnt", 32'(hostGnt), 1);
    checkEq("habort_mem_we", 32'(memWe), 0);
    cyc(); smp();
    checkEq("habort_release", 32'(hostGnt), 0);
    checkEq("habort_no_write", 32'(hostWrCnt - h0), 0);

    // Six back-to-back host writes with the CPU idle
    h0 = hostWrCnt; n = 0; gntHist = '0;
    for (int k = 0; k < 16; k++) begin
      cyc();
      hostReq = (n < 6); hostWe = 1'b1;
      hostAdr = 32'h300 + 32'(4 * n); hostWdata = 32'hB0 + 32'(n);
      smp();
      gntHist[k] = hostGnt;
      if (hostGnt && hostReq) n++;
    end
`ifdef DMEM_HOST_BURST_EN
    expHist = 16'h01DE;
`else
    expHist = 16'h0AAA;
`endif
    good = 0;
    for (int i = 0; i < 6; i++) if (mem[192 + i] == 32'hB0 + 32'(i)) good++;
    checkEq("burst_gnt_pattern", 32'(gntHist), 32'(expHist));
    checkEq("burst_write_count", 32'(hostWrCnt - h0), 32'd6);
    checkEq("burst_data_ok", 32'(good), 32'd6);

    // Reset while granted
    cyc(); hostReq = 1'b1; hostWe = 1'b1; hostAdr = 32'h20C; cpuActive = 1'b0;
    smp();
    cyc(); smp();
    checkEq("rstg_pre_gnt", 32'(hostGnt), 1);
    #2;
    reset = 1'b0; hostReq = 1'b0;
    cpuActive = 1'b1; cpuWe = 1'b1; cpuAdr = 32'h88; cpuWdata = 32'h77;
    #1;
    checkEq("rstg_gnt", 32'(hostGnt), 0);
    checkEq("rstg_mux_adr", memAdr, 32'h88);
    checkEq("rstg_mux_we", 32'(memWe), 1);

    // Reset while a read result is being presented
    cyc(); reset = 1'b1; cpuActive = 1'b0; cpuWe = 1'b0;
    hostReq = 1'b1; hostWe = 1'b0; hostAdr = 32'h40;
    smp();
    cyc(); smp();
    cyc(); hostReq = 1'b0;
    smp();
    checkEq("rstr_pre_rvalid", 32'(hostRvalid), 1);
    #2 reset = 1'b0;
    #1;
    checkEq("rstr_rvalid", 32'(hostRvalid), 0);
    checkEq("rstr_rdata", hostRdata, 0);
    cyc(); reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
